gmii_tx_mac: RTL and testbench
==============================

# gmii_tx_mac

Ethernet transmit framer for the GMII side of the Ethernet MAC. It accepts a frame as a byte stream starting at the destination MAC, with valid/ready/last handshaking. It emits a complete GMII frame: preamble, SFD, payload, zero-padding to minimum length, CRC-32 FCS, then the inter-frame gap. Its GMII outputs feed the GMII-to-RGMII converter on the same clock domain.

## Interface
- `MIN_FRAME`, 60: minimum byte count (destination MAC through payload, excluding FCS); shorter frames are zero-padded; 0 disables padding
- `IFG_CYCLES`, 12: idle cycles forced after every frame (good or aborted)
- `gmii_tx_clk`  in  1  125 MHz transmit clock; sole clock
- `reset_n`  in  1  reset, synchronous, active-low
- `s_tdata`  in  8  frame byte
- `s_tvalid`  in  1  byte valid
- `s_tlast`  in  1  last byte of frame
- `s_tready`  out  1  byte accepted when `s_tvalid & s_tready`
- `gmii_txd`  out  8  GMII transmit data
- `gmii_tx_en`  out  1  GMII transmit enable
- `gmii_tx_er`  out  1  GMII transmit error (underrun only)
- `tx_done`  out  1  one-cycle pulse on the cycle after the last FCS byte of a good frame
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- IDLE: `s_tready`=0. When `s_tvalid`=1 is sampled, go to PREAMBLE. `s_tdata` is not consumed in this cycle.
- PREAMBLE: 7 bytes of 0x55.
- SFD: 1 byte of 0xD5.
- DATA:
  - Each accepted byte appears on `gmii_txd` one cycle after acceptance.
  - An 11-bit byte counter, saturating at 2047, counts the accepted bytes.
  - The CRC register is initialised to 0xFFFFFFFF at SFD and updated with each output data byte. The algorithm is reflected, polynomial 0xEDB88320.
- Accepting `s_tlast`:
  - If counter < `MIN_FRAME`, go to PAD.
  - Otherwise go to FCS.
- PAD: emit 0x00 bytes, each included in the CRC, until the count reaches `MIN_FRAME`. Then go to FCS.
- FCS:
  - Emit ~CRC over 4 bytes, least-significant byte first.
  - On the cycle after the 4th byte, pulse `tx_done` and enter IFG.
- IFG: `gmii_tx_en`=0 and `s_tready`=0 for `IFG_CYCLES` cycles, then return to IDLE.
- Underrun: `s_tready`=1 and `s_tvalid`=0 in DATA.
  - The next output cycle has `gmii_tx_en`=1, `gmii_tx_er`=1 and `gmii_txd`=0x00.
  - Then enter DRAIN: `s_tready`=1, `gmii_tx_en`=0, input discarded until `s_tvalid & s_tlast`. Then go to IFG.
  - No FCS is sent and `tx_done` is not pulsed.
- `s_tlast` is ignored in PREAMBLE/SFD, because `s_tready`=0 there.
- A frame longer than 2047 bytes still transmits. Only the padding decision uses the counter.

## Timing
- All outputs are registered except `s_tready`, which is decoded from state and is combinational from registers only.
- `s_tvalid` sampled high in IDLE at cycle T gives:
  - `gmii_tx_en`=1 from T+1;
  - 0x55 on T+1..T+7;
  - 0xD5 on T+8;
  - first payload byte on T+9.
- `s_tready` is high from cycle T+8. A byte accepted at cycle k is output at k+1.
- Frame length on the wire is 8 + max(N, `MIN_FRAME`) + 4 cycles of `gmii_tx_en`, where N is the input byte count.
- Back-to-back frames with `s_tvalid` held: exactly `IFG_CYCLES` + 1 cycles with `gmii_tx_en`=0 between frames (IFG plus the IDLE sampling cycle).
- Reset values: `gmii_txd`=0x00, `gmii_tx_en`=0, `gmii_tx_er`=0, `tx_done`=0, `busy`=0, `s_tready`=0, state IDLE, counter 0, CRC 0xFFFFFFFF.
- `reset_n` low in any state forces the reset values on the next edge. The frame is truncated, no IFG is enforced, and the next frame starts normally.

## Structure
- Shared package `eth_pkg`:
  - constants for preamble byte 0x55, SFD 0xD5, CRC polynomial 0xEDB88320, CRC init 0xFFFFFFFF, CRC residue 0xDEBB20E3;
  - the state encoding.
- One sub-module `crc32_d8`: combinational next-CRC for one byte (crc_in[31:0], data[7:0] -> crc_out[31:0]). It is shared with the receive-side FCS checker.

## Test plan
- `MIN_FRAME`=0, send ASCII "123456789" -> `gmii_txd` = 7×0x55, 0xD5, 0x31..0x39, 0x26 0x39 0xF4 0xCB; `gmii_tx_en` high 21 cycles; `tx_done` one pulse.
- Default params, 14-byte frame -> 46 bytes of 0x00 after payload; `gmii_tx_en` high 72 cycles; CRC over bytes 9..72 gives residue 0xDEBB20E3.
- Two frames, `s_tvalid` held high -> exactly 13 cycles of `gmii_tx_en`=0 between frames; no byte lost or duplicated.
- Drop `s_tvalid` at byte 20 of a 100-byte frame -> one cycle `tx_en`=1/`tx_er`=1/txd 0x00; no FCS; `s_tready` high until `s_tlast`; 12 IFG cycles; no `tx_done`.
- `reset_n` low for 1 cycle during DATA -> next cycle all outputs at reset values; a following frame has correct preamble and FCS.
- 1514-byte frame -> no padding; `gmii_tx_en` high 1526 cycles; FCS matches the software model.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and transmit FSM state encoding.
// Used by the GMII transmit framer and the receive-side FCS checker.
package eth_pkg;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_PAD      = 3'd4;
    localparam logic [2:0] ST_FCS      = 3'd5;
    localparam logic [2:0] ST_IFG      = 3'd6;
    localparam logic [2:0] ST_DRAIN    = 3'd7;
endpackage

// File: rtl/gmii_tx_mac_if.sv
// Byte-stream handshake feeding the GMII transmit framer.
interface gmii_tx_mac_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input  s_tready);
    modport slave  (input  s_tdata, input  s_tvalid, input  s_tlast, output s_tready);
endinterface

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit framer: preamble, SFD, payload, zero pad, FCS and inter-frame gap.
//
// state    | meaning
// IDLE     | waiting for s_tvalid, nothing consumed
// PREAMBLE | emitting 0x55 bytes
// SFD      | 0xD5 on the wire, first payload byte being accepted
// DATA     | forwarding accepted bytes, CRC running
// PAD      | emitting 0x00 until the minimum length is reached
// FCS      | emitting ~CRC LSB first, then pulsing tx_done
// IFG      | forced idle gap
// DRAIN    | after underrun, discarding input up to s_tlast
module gmii_tx_mac
    import eth_pkg::*;
#(
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic          gmii_tx_clk,
    input  logic          reset_n,
    gmii_tx_mac_if.slave  s_axis,
    output logic [7:0]    gmii_txd,
    output logic          gmii_tx_en,
    output logic          gmii_tx_er,
    output logic          tx_done,
    output logic          busy
);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
    localparam logic [15:0] IFG_LOAD = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

    logic [2:0]  state_q, state_d;
    logic [10:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0] tmr_q, tmr_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic [7:0]  txd_q, txd_d, crc_byte;
    logic        en_q, en_d, er_q, er_d, done_q, done_d, busy_q;

    assign s_axis.s_tready = (state_q == ST_SFD) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign crc_byte = (state_q == ST_PAD) ? 8'h00 : s_axis.s_tdata;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        crc_d   = crc_q;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_axis.s_tvalid) begin
                    state_d = ST_PREAMBLE;
                    en_d    = 1'b1;
                    txd_d   = PREAMBLE_BYTE;
                    tmr_d   = 16'd6;
                    cnt_d   = 11'd0;
                end
            end
            ST_PREAMBLE: begin
                en_d = 1'b1;
                if (tmr_q == 16'd0) begin
                    txd_d   = SFD_BYTE;
                    crc_d   = CRC_INIT;
                    state_d = ST_SFD;
                end else begin
                    txd_d = PREAMBLE_BYTE;
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_SFD, ST_DATA: begin
                en_d = 1'b1;
                if (s_axis.s_tvalid) begin
                    txd_d   = s_axis.s_tdata;
                    crc_d   = crc_next;
                    cnt_d   = cnt_inc;
                    state_d = ST_DATA;
                    if (s_axis.s_tlast) begin
                        if (cnt_inc < MIN_CNT) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_FCS;
                            tmr_d   = 16'd4;
                        end
                    end
                end else begin
                    er_d    = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_PAD: begin
                en_d  = 1'b1;
                crc_d = crc_next;
                cnt_d = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    state_d = ST_FCS;
                    tmr_d   = 16'd4;
                end
            end
            ST_FCS: begin
                if (tmr_q == 16'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IFG;
                    tmr_d   = IFG_LOAD;
                end else begin
                    // Shift the FCS out a byte at a time; 0xFF fill leaves the register at CRC_INIT.
                    en_d  = 1'b1;
                    txd_d = ~crc_q[7:0];
                    crc_d = {8'hFF, crc_q[31:8]};
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_IFG: begin
                if (tmr_q == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_DRAIN: begin
                if (s_axis.s_tvalid && s_axis.s_tlast) begin
                    state_d = ST_IFG;
                    tmr_d   = IFG_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 11'd0;
            tmr_q   <= 16'd0;
            crc_q   <= CRC_INIT;
            txd_q   <= 8'h00;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            en_q    <= en_d;
            er_q    <= er_d;
            done_q  <= done_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = en_q;
    assign gmii_tx_er = er_q;
    assign tx_done    = done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_gmii_tx_mac.sv
// Scoreboard bench for gmii_tx_mac: default instance plus a MIN_FRAME=0 instance.
module tb_gmii_tx_mac;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic       reset_n;
    logic       tb_valid, tb_last, sel;
    logic [7:0] tb_data;

    gmii_tx_mac_if ifa ();
    gmii_tx_mac_if ifb ();

    assign ifa.s_tdata  = tb_data;
    assign ifa.s_tlast  = tb_last;
    assign ifa.s_tvalid = tb_valid & ~sel;
    assign ifb.s_tdata  = tb_data;
    assign ifb.s_tlast  = tb_last;
    assign ifb.s_tvalid = tb_valid & sel;

    logic [7:0] txd_a, txd_b;
    logic       en_a, en_b, er_a, er_b, done_a, done_b, busy_a, busy_b;

    gmii_tx_mac dut_a (
        .gmii_tx_clk (clk),
        .reset_n     (reset_n),
        .s_axis      (ifa),
        .gmii_txd    (txd_a),
        .gmii_tx_en  (en_a),
        .gmii_tx_er  (er_a),
        .tx_done     (done_a),
        .busy        (busy_a)
    );

    gmii_tx_mac #(.MIN_FRAME(0)) dut_b (
        .gmii_tx_clk (clk),
        .reset_n     (reset_n),
        .s_axis      (ifb),
        .gmii_txd    (txd_b),
        .gmii_tx_en  (en_b),
        .gmii_tx_er  (er_b),
        .tx_done     (done_b),
        .busy        (busy_b)
    );

    logic [7:0] m_txd;
    logic       m_en, m_er, m_done, m_busy, m_ready;
    assign m_txd   = sel ? txd_b : txd_a;
    assign m_en    = sel ? en_b : en_a;
    assign m_er    = sel ? er_b : er_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_ready = sel ? ifb.s_tready : ifa.s_tready;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic bq_t rand_pl(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    logic [8:0] exp_q[$];

    task automatic push_head();
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
    endtask

    task automatic push_exp(input bq_t p, input int min_len);
        logic [31:0] c;
        logic [31:0] f;
        c = 32'hFFFFFFFF;
        push_head();
        foreach (p[i]) begin
            exp_q.push_back({1'b0, p[i]});
            c = crc_upd(c, p[i]);
        end
        for (int i = p.size(); i < min_len; i++) begin
            exp_q.push_back(9'h000);
            c = crc_upd(c, 8'h00);
        end
        f = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, f[8*k +: 8]});
    endtask

    task automatic put_byte(input logic [7:0] d, input logic last, output int waited);
        tb_data  = d;
        tb_last  = last;
        tb_valid = 1'b1;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_ready && waited < 3000);
        if (!m_ready) chk("ready_timeout", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bq_t p, input int n_send, input bit with_last, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < n_send; i++) begin
            put_byte(p[i], with_last && (i == p.size() - 1), w);
            if (i == 0) first_wait = w;
        end
    endtask

    task automatic stop_drive();
        tb_valid = 1'b0;
        tb_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m_busy || m_en) && n < 5000);
        if (m_busy) chk("idle_timeout", 32'(m_busy), 32'd0);
        @(negedge clk);
    endtask

    // Wire monitor: pops the scoreboard on every tx_en cycle and tracks frame length, gap and residue.
    int          pos = 0, last_len = 0, gap = 0, last_gap = 0, done_cnt = 0;
    logic [31:0] rx_crc = 32'hFFFFFFFF, last_crc = 32'h0;

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (m_done) begin
                done_cnt++;
                chk("done_align", 32'(!m_en && pos != 0), 32'd1);
            end
            if (m_en) begin
                if (pos == 0) begin
                    rx_crc   = 32'hFFFFFFFF;
                    last_gap = gap;
                end
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 9'h1FF;
                chk("wire_byte", 32'({m_er, m_txd}), 32'(e));
                if (pos >= 8) rx_crc = crc_upd(rx_crc, m_txd);
                pos++;
                gap = 0;
            end else begin
                if (pos != 0) begin
                    last_len = pos;
                    last_crc = rx_crc;
                    pos      = 0;
                end
                gap++;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_txd"},   32'(txd_a), 32'd0);
        chk({tag, "_en"},    32'(en_a), 32'd0);
        chk({tag, "_er"},    32'(er_a), 32'd0);
        chk({tag, "_done"},  32'(done_a), 32'd0);
        chk({tag, "_busy"},  32'(busy_a), 32'd0);
        chk({tag, "_ready"}, 32'(ifa.s_tready), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t p, p2;
        int  w, d0, n;

        reset_n  = 1'b0;
        sel      = 1'b0;
        tb_data  = 8'h00;
        stop_drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // "123456789" with padding disabled: check vector 0xCBF43926.
        sel = 1'b1;
        p.delete();
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        foreach (p[i]) exp_q.push_back({1'b0, p[i]});
        exp_q.push_back(9'h026);
        exp_q.push_back(9'h039);
        exp_q.push_back(9'h0F4);
        exp_q.push_back(9'h0CB);
        d0 = done_cnt;
        send(p, p.size(), 1'b1, w);
        stop_drive();
        chk("ready_latency", 32'(w), 32'd9);
        wait_idle();
        chk("ascii_len", 32'(last_len), 32'd21);
        chk("ascii_done", 32'(done_cnt - d0), 32'd1);
        chk("ascii_residue", last_crc, eth_pkg::CRC_RESIDUE);
        chk("ascii_q_empty", 32'(exp_q.size()), 32'd0);

        // Short frame padded to 60 bytes.
        sel = 1'b0;
        @(negedge clk);
        p = rand_pl(14);
        push_exp(p, 60);
        d0 = done_cnt;
        send(p, p.size(), 1'b1, w);
        stop_drive();
        wait_idle();
        chk("pad_len", 32'(last_len), 32'd72);
        chk("pad_done", 32'(done_cnt - d0), 32'd1);
        chk("pad_residue", last_crc, eth_pkg::CRC_RESIDUE);
        chk("pad_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with s_tvalid held.
        p  = rand_pl(64);
        p2 = rand_pl(70);
        push_exp(p, 60);
        push_exp(p2, 60);
        d0 = done_cnt;
        send(p, p.size(), 1'b1, w);
        send(p2, p2.size(), 1'b1, w);
        stop_drive();
        wait_idle();
        chk("b2b_gap", 32'(last_gap), 32'd13);
        chk("b2b_len", 32'(last_len), 32'd82);
        chk("b2b_done", 32'(done_cnt - d0), 32'd2);
        chk("b2b_residue", last_crc, eth_pkg::CRC_RESIDUE);
        chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Underrun at byte 20 of a 100-byte frame.
        p = rand_pl(100);
        push_head();
        for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, p[i]});
        exp_q.push_back(9'h100);
        d0 = done_cnt;
        send(p, 20, 1'b0, w);
        tb_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 20; i < 100; i++) begin
            tb_data  = p[i];
            tb_last  = (i == 99);
            tb_valid = 1'b1;
            @(negedge clk);
            chk("drain_ready", 32'(m_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        stop_drive();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!m_busy) break;
            n++;
        end
        chk("underrun_ifg", 32'(n), 32'd12);
        wait_idle();
        chk("underrun_len", 32'(last_len), 32'd29);
        chk("underrun_no_done", 32'(done_cnt - d0), 32'd0);
        chk("underrun_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset pulse mid-DATA, then a normal frame.
        p = rand_pl(40);
        push_exp(p, 60);
        send(p, 30, 1'b0, w);
        reset_n = 1'b0;
        stop_drive();
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst");
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        p = rand_pl(20);
        push_exp(p, 60);
        d0 = done_cnt;
        send(p, p.size(), 1'b1, w);
        stop_drive();
        wait_idle();
        chk("postrst_len", 32'(last_len), 32'd72);
        chk("postrst_done", 32'(done_cnt - d0), 32'd1);
        chk("postrst_residue", last_crc, eth_pkg::CRC_RESIDUE);
        chk("postrst_q_empty", 32'(exp_q.size()), 32'd0);

        // Full-size frame, no padding.
        p = rand_pl(1514);
        push_exp(p, 60);
        d0 = done_cnt;
        send(p, p.size(), 1'b1, w);
        stop_drive();
        wait_idle();
        chk("max_len", 32'(last_len), 32'd1526);
        chk("max_done", 32'(done_cnt - d0), 32'd1);
        chk("max_residue", last_crc, eth_pkg::CRC_RESIDUE);
        chk("max_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
